ptr_seq_ctrl: RTL

//  Sequencer directly upstream of the base/increment pointer register. It drives

---
 rtl/ptr_seq_ctrl.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/ptr_seq_ctrl.sv
// ---------------------------------------------------------------------------
// ptr_seq_ctrl
// Sequencer that sits directly in front of a base/increment pointer register.
// It pulses the register's INC input to walk Len element addresses, pulses its
// RST input to rewind to the base between passes, repeats for Reps passes and
// then emits a one-cycle Done. The base value itself is loaded elsewhere.
//
// Ports
//   Clk     in   1   clock, all state updates on rising edge
//   RST     in   1   synchronous active-high block reset
//   Start   in   1   request a new sequence (only honoured in IDLE)
//   Len     in   CW  elements per pass, captured on an accepted Start
//   Reps    in   CW  number of passes, captured on an accepted Start
//   Stall   in   1   consumer not ready, freezes the sweep
//   Abort   in   1   cancel the active sequence
//   PtrInc  out  1   advance the pointer at this edge
//   PtrRst  out  1   reload the pointer base at this edge
//   Valid   out  1   pointer holds a live element address this cycle
//   Busy    out  1   a sequence is in progress
//   Done    out  1   single-cycle pulse on normal completion
//   Idx     out  CW  element index within the current pass
//   Pass    out  CW  current pass number, 0-based
//
// PtrInc/PtrRst/Valid/Done are decoded combinationally from the state
// register, Stall, Abort and Idx so the pointer moves on the same edge the
// sequencer decides to move; Busy, Idx and Pass come straight from registers.
// ---------------------------------------------------------------------------
module ptr_seq_ctrl #(
    parameter int CW = 8
) (
    input  logic          Clk,
    input  logic          RST,
    input  logic          Start,
    input  logic [CW-1:0] Len,
    input  logic [CW-1:0] Reps,
    input  logic          Stall,
    input  logic          Abort,
    output logic          PtrInc,
    output logic          PtrRst,
    output logic          Valid,
    output logic          Busy,
    output logic          Done,
    output logic [CW-1:0] Idx,
    output logic [CW-1:0] Pass
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_REWIND = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [CW-1:0] ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] ONE  = {{(CW-1){1'b0}}, 1'b1};

    state_t        r_state;
    logic [CW-1:0] r_idx;
    logic [CW-1:0] r_pass;
    logic [CW-1:0] r_len;
    logic [CW-1:0] r_reps;

    state_t        w_state_nxt;
    logic [CW-1:0] w_idx_nxt;
    logic [CW-1:0] w_pass_nxt;
    logic [CW-1:0] w_len_nxt;
    logic [CW-1:0] w_reps_nxt;
    logic          w_ptr_inc;
    logic          w_ptr_rst;
    logic          w_valid;
    logic          w_done;
    logic          w_last_idx;
    logic          w_last_pass;

    // Latched Len/Reps are never zero while in RUN, so the subtraction cannot wrap there.
    assign w_last_idx  = (r_idx  == (r_len  - ONE));
    assign w_last_pass = (r_pass == (r_reps - ONE));

    // State and counter registers with synchronous block reset.
    always_ff @(posedge Clk) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_idx   <= ZERO;
            r_pass  <= ZERO;
            r_len   <= ZERO;
            r_reps  <= ZERO;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_pass  <= w_pass_nxt;
            r_len   <= w_len_nxt;
            r_reps  <= w_reps_nxt;
        end
    end

    // Next-state, counter update and pointer-control decode.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_pass_nxt  = r_pass;
        w_len_nxt   = r_len;
        w_reps_nxt  = r_reps;
        w_ptr_inc   = 1'b0;
        w_ptr_rst   = 1'b0;
        w_valid     = 1'b0;
        w_done      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (Start) begin
                    w_idx_nxt  = ZERO;
                    w_pass_nxt = ZERO;
                    if ((Len != ZERO) && (Reps != ZERO)) begin
                        w_len_nxt   = Len;
                        w_reps_nxt  = Reps;
                        w_state_nxt = ST_RUN;
                    end else begin
                        // Empty sequence: report completion without touching the pointer.
                        w_state_nxt = ST_DONE;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_RUN: begin
                // The address is live whenever the consumer is ready, even on an aborting edge.
                w_valid = !Stall;
                if (Abort) begin
                    w_ptr_rst   = 1'b1;
                    w_idx_nxt   = ZERO;
                    w_pass_nxt  = ZERO;
                    w_state_nxt = ST_IDLE;
                end else if (Stall) begin
                    w_state_nxt = ST_RUN;
                end else if (!w_last_idx) begin
                    w_ptr_inc   = 1'b1;
                    w_idx_nxt   = r_idx + ONE;
                    w_state_nxt = ST_RUN;
                end else if (!w_last_pass) begin
                    // Last element of a non-final pass: rewind rather than step past the end.
                    w_pass_nxt  = r_pass + ONE;
                    w_state_nxt = ST_REWIND;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end

            ST_REWIND: begin
                w_ptr_rst = 1'b1;
                w_idx_nxt = ZERO;
                if (Abort) begin
                    w_pass_nxt  = ZERO;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end

            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                if (Abort) begin
                    w_ptr_rst  = 1'b1;
                    w_idx_nxt  = ZERO;
                    w_pass_nxt = ZERO;
                end else begin
                    w_done = 1'b1;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_idx_nxt   = ZERO;
                w_pass_nxt  = ZERO;
            end
        endcase
    end

    assign PtrInc = w_ptr_inc;
    assign PtrRst = w_ptr_rst;
    assign Valid  = w_valid;
    assign Done   = w_done;
    assign Busy   = (r_state != ST_IDLE);
    assign Idx    = r_idx;
    assign Pass   = r_pass;

endmodule
